apb_master_arbiter: RTL and testbench

Two-requester APB master that shares a single APB bus between two internal clients. It arbitrates round-robin, sequences the APB SETUP/ACCESS phases toward the GPIO slave, and waits on `pready`. It returns read data or an error to the granted client, and aborts a transfer that stalls past a timeout. It sits between the test/firmware-side request agents and the APB GPIO slave port.

---
 rtl/apb_master_arbiter.sv | 120 ++++++++++++
 tb/tb_apb_master_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Two-client APB master with round-robin arbitration, wait-state handling and
// a timeout abort for slaves that never raise pready.
module apb_master_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_done,
  output logic                req_err,
  output logic [DATA_W-1:0]   req_rdata,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rr;
  logic                r_grant;
  logic                w_grant;
  logic                w_timeout;
  logic                w_psel_d;
  logic                w_penable_d;
  logic [1:0]          w_done_d;
  logic                w_write;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  // Both valid: rr decides; otherwise the only valid client wins.
  always_comb begin
    w_grant = (&req_valid) ? r_rr : req_valid[1];
    w_write = w_grant ? req_write[1] : req_write[0];
    w_addr  = w_grant ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    w_wdata = w_grant ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  end

  // Fires on the ACCESS cycle whose stall would make the count reach TIMEOUT.
  assign w_timeout = (TIMEOUT > 0) && !pready && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge pclk) begin
    if (preset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (|req_valid) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (pready || w_timeout) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered copies line up
  // with the state they belong to.
  always_comb begin
    w_psel_d    = (w_next == S_SETUP) || (w_next == S_ACCESS);
    w_penable_d = (w_next == S_ACCESS);
    w_done_d    = 2'b00;
    if (w_next == S_DONE) w_done_d = r_grant ? 2'b10 : 2'b01;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      req_done  <= 2'b00;
      req_err   <= 1'b0;
      req_rdata <= '0;
      r_rr      <= 1'b0;
      r_grant   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      psel     <= w_psel_d;
      penable  <= w_penable_d;
      req_done <= w_done_d;

      if (r_state == S_IDLE && w_next == S_SETUP) begin
        r_grant <= w_grant;
        r_rr    <= ~w_grant;
        pwrite  <= w_write;
        paddr   <= w_addr;
        pwdata  <= w_wdata;
      end

      if (r_state == S_SETUP)
        r_cnt <= '0;
      else if (r_state == S_ACCESS && !pready)
        r_cnt <= r_cnt + 1'b1;

      if (r_state == S_ACCESS && w_next == S_DONE) begin
        req_err   <= !pready;
        req_rdata <= (pready && !pwrite) ? prdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: a programmable-wait APB slave,
// a completion scoreboard and one task per scenario.
module tb_apb_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            pclk = 1'b0;
  logic            preset;
  logic [1:0]      req_valid;
  logic [1:0]      req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_done;
  logic            req_err;
  logic [DW-1:0]   req_rdata;
  logic            psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW-1:0]   prdata;
  logic            pready;

  apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int            client;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            slave_wait = 0;
  logic [DW-1:0] slave_rdata = '0;
  int            acc_cnt = 0;
  int            cyc = 0;
  int            last_done_cyc = 0;
  int            done_gap = 0;
  int            total_dones = 0;
  logic          seen_write = 1'b0;
  logic [AW-1:0] seen_addr = '0;
  logic [DW-1:0] seen_wdata = '0;
  logic [1:0]    prev_done = 2'b00;

  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  // APB slave: raises pready after slave_wait stalled ACCESS cycles.
  initial begin
    pready = 1'b0;
    prdata = '0;
    forever begin
      @(negedge pclk);
      if (psel && penable) begin
        seen_write = pwrite;
        seen_addr  = paddr;
        seen_wdata = pwdata;
        if (acc_cnt == slave_wait) begin
          pready = 1'b1;
          prdata = slave_rdata;
        end else begin
          pready = 1'b0;
          prdata = '0;
        end
        acc_cnt++;
      end else begin
        pready  = 1'b0;
        prdata  = '0;
        acc_cnt = 0;
      end
    end
  end

  // Completion monitor: pops the scoreboard on every req_done pulse and
  // drops the finished client's req_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (req_done != 2'b00) begin
        total_dones++;
        done_gap      = cyc - last_done_cyc;
        last_done_cyc = cyc;
        n_checks++;
        if (prev_done === 2'b00) n_pass++;
        else $display("FAIL done_width: req_done high on consecutive cycles (%b then %b)", prev_done, req_done);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: req_done=%b with nothing outstanding", req_done);
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (req_done === (2'b01 << e.client)) n_pass++;
          else $display("FAIL done_client: got %b expected %b", req_done, 2'b01 << e.client);
          n_checks++;
          if (req_err === e.err) n_pass++;
          else $display("FAIL req_err: got %b expected %b", req_err, e.err);
          n_checks++;
          if (req_rdata === e.rdata) n_pass++;
          else $display("FAIL req_rdata: got %h expected %h", req_rdata, e.rdata);
          n_checks++;
          if ({seen_write, seen_addr, seen_wdata} === {e.write, e.addr, e.wdata}) n_pass++;
          else $display("FAIL bus_fields: got w=%b a=%h d=%h expected w=%b a=%h d=%h",
                        seen_write, seen_addr, seen_wdata, e.write, e.addr, e.wdata);
        end
        for (int c = 0; c < 2; c++) if (req_done[c]) req_valid[c] = 1'b0;
      end
      prev_done = req_done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic issue(input int c, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] rd,
                       input logic er, input bit expect_done);
    exp_t e;
    req_write[c]           = w;
    req_addr[c*AW +: AW]   = a;
    req_wdata[c*DW +: DW]  = d;
    req_valid[c]           = 1'b1;
    if (expect_done) begin
      e.client = c;
      e.write  = w;
      e.addr   = a;
      e.wdata  = d;
      e.rdata  = (er || w) ? '0 : rd;
      e.err    = er;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge pclk);
      k++;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      $display("FAIL drain_timeout: %0d completions outstanding after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (2) @(negedge pclk);
  endtask

  task automatic measure_access(output int n_acc);
    n_acc = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge pclk);
      if (psel && penable) n_acc++;
      if (req_done != 2'b00) break;
    end
  endtask

  task automatic do_reset();
    preset    = 1'b1;
    req_valid = 2'b00;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
  endtask

  task automatic test_reset();
    preset    = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge pclk);
    n_checks++;
    if ({psel, penable, pwrite, req_done, req_err} === 6'b0) n_pass++;
    else $display("FAIL reset_ctrl: got %b expected 000000", {psel, penable, pwrite, req_done, req_err});
    n_checks++;
    if (paddr === '0) n_pass++;
    else $display("FAIL reset_paddr: got %h expected 0", paddr);
    n_checks++;
    if (pwdata === '0) n_pass++;
    else $display("FAIL reset_pwdata: got %h expected 0", pwdata);
    n_checks++;
    if (req_rdata === '0) n_pass++;
    else $display("FAIL reset_rdata: got %h expected 0", req_rdata);
    preset = 1'b0;
    @(negedge pclk);
  endtask

  task automatic test_write();
    slave_wait = 0;
    issue(0, 1'b1, 32'h04, 32'hA5A5_0001, '0, 1'b0, 1'b1);
    @(negedge pclk);
    n_checks++;
    if ({psel, penable} === 2'b10) n_pass++;
    else $display("FAIL setup_phase: got psel/penable=%b expected 10", {psel, penable});
    @(negedge pclk);
    n_checks++;
    if ({psel, penable, pwrite, paddr, pwdata} === {3'b111, 32'h04, 32'hA5A5_0001}) n_pass++;
    else $display("FAIL access_phase: got sel=%b en=%b w=%b a=%h d=%h expected 1 1 1 4 a5a50001",
                  psel, penable, pwrite, paddr, pwdata);
    @(negedge pclk);
    n_checks++;
    if ({req_done, psel, penable} === 4'b0100) n_pass++;
    else $display("FAIL write_done_cycle: got done=%b sel=%b en=%b expected 01 0 0", req_done, psel, penable);
    drain(20);
  endtask

  task automatic test_read_wait();
    int n_acc;
    slave_wait  = 3;
    slave_rdata = 32'h0000_00FF;
    issue(1, 1'b0, 32'h08, '0, slave_rdata, 1'b0, 1'b1);
    measure_access(n_acc);
    n_checks++;
    if (n_acc == 4) n_pass++;
    else $display("FAIL read_access_len: got %0d cycles expected 4", n_acc);
    drain(20);
    n_checks++;
    if (req_rdata === 32'h0000_00FF) n_pass++;
    else $display("FAIL rdata_hold: got %h expected 000000ff", req_rdata);
  endtask

  task automatic test_round_robin();
    do_reset();
    slave_wait = 0;
    issue(0, 1'b1, 32'h10, 32'h1111_0000, '0, 1'b0, 1'b1);
    issue(1, 1'b1, 32'h14, 32'h2222_0000, '0, 1'b0, 1'b1);
    drain(40);
    n_checks++;
    if (done_gap == 4) n_pass++;
    else $display("FAIL back_to_back_gap: got %0d cycles expected 4", done_gap);
    slave_wait  = 1;
    slave_rdata = 32'h1234_5678;
    total_dones = 0;
    issue(0, 1'b0, 32'h18, '0, slave_rdata, 1'b0, 1'b1);
    issue(1, 1'b0, 32'h1C, '0, slave_rdata, 1'b0, 1'b1);
    drain(40);
    repeat (8) @(negedge pclk);
    n_checks++;
    if (total_dones == 2) n_pass++;
    else $display("FAIL rr_done_count: got %0d completions expected 2", total_dones);
  endtask

  task automatic test_timeout();
    int n_acc;
    slave_wait  = 1_000_000;
    slave_rdata = 32'hCAFE_F00D;
    issue(0, 1'b0, 32'h20, '0, '0, 1'b1, 1'b1);
    measure_access(n_acc);
    n_checks++;
    if (n_acc == TO) n_pass++;
    else $display("FAIL timeout_len: got %0d cycles expected %0d", n_acc, TO);
    n_checks++;
    if ({psel, penable} === 2'b00) n_pass++;
    else $display("FAIL timeout_bus_drop: got psel/penable=%b expected 00", {psel, penable});
    drain(20);
    slave_wait = 0;
    issue(1, 1'b0, 32'h24, '0, slave_rdata, 1'b0, 1'b1);
    drain(20);
  endtask

  task automatic test_reset_abort();
    int k = 0;
    slave_wait = 1_000_000;
    issue(0, 1'b1, 32'h30, 32'hDEAD_BEEF, '0, 1'b0, 1'b0);
    while (!(psel && penable) && k < 20) begin
      @(negedge pclk);
      k++;
    end
    n_checks++;
    if (psel && penable) n_pass++;
    else $display("FAIL abort_reach_access: got sel=%b en=%b expected 1 1", psel, penable);
    preset = 1'b1;
    @(negedge pclk);
    n_checks++;
    if ({psel, penable, req_done} === 4'b0000) n_pass++;
    else $display("FAIL abort_outputs: got sel=%b en=%b done=%b expected 0 0 00", psel, penable, req_done);
    preset       = 1'b0;
    req_valid[0] = 1'b0;
    slave_wait   = 0;
    slave_rdata  = 32'h0BAD_F00D;
    issue(1, 1'b0, 32'h34, '0, slave_rdata, 1'b0, 1'b1);
    @(negedge pclk);
    n_checks++;
    if ({psel, penable, paddr} === {2'b10, 32'h34}) n_pass++;
    else $display("FAIL post_reset_setup: got sel=%b en=%b a=%h expected 1 0 34", psel, penable, paddr);
    drain(20);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_round_robin();
    test_timeout();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
